// File: rtl/rib_arbiter.sv
// rtl/rib_arbiter.sv - RIB bus arbiter: master 3 priority, round-robin 0/1/2, slow-slave lock
// Optional LOCK timeout is enabled by defining RIB_ARB_TIMEOUT_EN.
module rib_arbiter #(
  parameter logic [3:0] SLOW_SLAVE     = 4'h7,
  parameter logic [7:0] TIMEOUT_CYCLES = 8'd255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_i,
  input  logic [3:0] slv_sel_i,
  input  logic       s7_data_valid_i,
  output logic [1:0] grant_o,
  output logic       grant_valid_o,
  output logic       hold_flag_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {IDLE, BUSY, LOCK} state_t;

  state_t     state, state_nxt;
  logic [1:0] last_rr, last_rr_nxt;
  logic [1:0] grant_nxt;
  logic [1:0] winner;
  logic       grant_valid_nxt;
  logic       timeout_nxt;
  logic       complete;
  logic       any_req;
  logic       req_granted;
  logic       lock_expired;

  assign any_req     = |req_i;
  assign req_granted = req_i[grant_o];
  assign hold_flag_o = (state == LOCK) | req_i[0] | req_i[2] | req_i[3];

  // Search order among 0/1/2 starts just after the last round-robin winner.
  always_comb begin
    winner = 2'd3;
    if (!req_i[3]) begin
      case (last_rr)
        2'd0:    winner = req_i[1] ? 2'd1 : (req_i[2] ? 2'd2 : 2'd0);
        2'd1:    winner = req_i[2] ? 2'd2 : (req_i[0] ? 2'd0 : 2'd1);
        default: winner = req_i[0] ? 2'd0 : (req_i[1] ? 2'd1 : 2'd2);
      endcase
    end
  end

`ifdef RIB_ARB_TIMEOUT_EN
  logic [7:0] lock_cnt;

  assign lock_expired = (lock_cnt == TIMEOUT_CYCLES - 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      lock_cnt <= 8'd0;
    else if (state != LOCK)
      lock_cnt <= 8'd0;
    else
      lock_cnt <= lock_cnt + 8'd1;
  end
`else
  // No timeout: LOCK is left only by valid data or a request drop.
  assign lock_expired = 1'b0 & (TIMEOUT_CYCLES == 8'd0);
`endif

  always_comb begin
    state_nxt       = state;
    grant_nxt       = grant_o;
    grant_valid_nxt = grant_valid_o;
    last_rr_nxt     = last_rr;
    timeout_nxt     = 1'b0;
    complete        = 1'b0;
    case (state)
      IDLE: complete = 1'b1;
      BUSY: begin
        if ((slv_sel_i == SLOW_SLAVE) && req_granted)
          state_nxt = LOCK;
        else
          complete = 1'b1;
      end
      LOCK: begin
        if (s7_data_valid_i || !req_granted) begin
          complete = 1'b1;
        end else if (lock_expired) begin
          complete    = 1'b1;
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (complete) begin
      if (any_req) begin
        grant_nxt       = winner;
        grant_valid_nxt = 1'b1;
        state_nxt       = BUSY;
        if (!req_i[3])
          last_rr_nxt = winner;
      end else begin
        grant_valid_nxt = 1'b0;
        state_nxt       = IDLE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      grant_o       <= 2'b00;
      grant_valid_o <= 1'b0;
      last_rr       <= 2'd2;
      timeout_o     <= 1'b0;
    end else begin
      state         <= state_nxt;
      grant_o       <= grant_nxt;
      grant_valid_o <= grant_valid_nxt;
      last_rr       <= last_rr_nxt;
      timeout_o     <= timeout_nxt;
    end
  end

endmodule

// File: tb/tb_rib_arbiter.sv
// tb/tb_rib_arbiter.sv - self-checking bench for rib_arbiter against a behavioural model
module tb_rib_arbiter;

  localparam logic [7:0] TO = 8'd8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] slv;
  logic       s7;
  logic [1:0] grant;
  logic       gv;
  logic       hold;
  logic       tout;

  int total = 0;
  int bad   = 0;

  logic [1:0] m_grant, m_last;
  logic       m_gv, m_locked, m_tout;
  int         m_lock_cycles;
  logic [1:0] exp_seq [4];

  always #5 clk = ~clk;

  rib_arbiter #(.SLOW_SLAVE(4'h7), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_i(req), .slv_sel_i(slv), .s7_data_valid_i(s7),
    .grant_o(grant), .grant_valid_o(gv), .hold_flag_o(hold), .timeout_o(tout)
  );

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_grant = 2'd0; m_last = 2'd2; m_gv = 1'b0; m_locked = 1'b0;
    m_tout = 1'b0; m_lock_cycles = 0;
  endtask

  // One clock of the bus rules: who finishes, who wins, what is held.
  task automatic model_step();
    bit done;
    int c;
    done   = 0;
    m_tout = 1'b0;
    if (!m_gv) done = 1;
    else if (!m_locked) begin
      if (slv == 4'h7 && req[m_grant]) begin
        m_locked = 1'b1; m_lock_cycles = 0;
      end else done = 1;
    end else begin
      if (s7 || !req[m_grant]) done = 1;
`ifdef RIB_ARB_TIMEOUT_EN
      else if (m_lock_cycles == int'(TO) - 1) begin done = 1; m_tout = 1'b1; end
`endif
      else m_lock_cycles++;
    end
    if (done) begin
      m_locked = 1'b0;
      if (req == 4'b0) m_gv = 1'b0;
      else begin
        m_gv = 1'b1;
        if (req[3]) m_grant = 2'd3;
        else begin
          for (int k = 3; k >= 1; k--) begin
            c = (int'(m_last) + k) % 3;
            if (req[c]) m_grant = 2'(c);
          end
          m_last = m_grant;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    chk("hold", {1'b0, hold}, {1'b0, m_locked | req[0] | req[2] | req[3]});
    model_step();
    @(posedge clk);
    #1;
    chk("grant", grant, m_grant);
    chk("grant_valid", {1'b0, gv}, {1'b0, m_gv});
    chk("timeout", {1'b0, tout}, {1'b0, m_tout});
  endtask

  task automatic do_reset();
    req = 4'b0; s7 = 1'b0; slv = 4'h0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b1; req = 4'b0; slv = 4'h0; s7 = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_grant", grant, 2'd0);
    chk("rst_gv", {1'b0, gv}, 2'd0);
    chk("rst_tout", {1'b0, tout}, 2'd0);
    chk("rst_hold", {1'b0, hold}, 2'd0);
    rst = 1'b0;

    // round robin over 0/1/2
    exp_seq[0] = 2'd0; exp_seq[1] = 2'd1; exp_seq[2] = 2'd2; exp_seq[3] = 2'd0;
    req = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("rr_seq", grant, exp_seq[i]);
    end

    // master 3 priority, then rotation resumes from last_rr=2
    do_reset();
    req = 4'b1011;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("m3_prio", grant, 2'd3);
    end
    req = 4'b0011;
    cycle();
    chk("resume0", grant, 2'd0);
    cycle();
    chk("resume1", grant, 2'd1);

    // slow-slave lock released by valid, master 3 waits
    do_reset();
    req = 4'b0001; slv = 4'h7;
    cycle();
    req = 4'b1001;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("lock_hold", grant, 2'd0);
    end
    s7 = 1'b1;
    cycle();
    chk("lock_to_m3", grant, 2'd3);
    s7 = 1'b0; slv = 4'h0; req = 4'b0;
    cycle();
    cycle();

    // long lock with no valid: timeout or indefinite wait
    req = 4'b0001; slv = 4'h7;
    for (int i = 0; i < 1000; i++) cycle();
`ifndef RIB_ARB_TIMEOUT_EN
    chk("lock_persist", grant, 2'd0);
`endif

    // abort by request drop
    do_reset();
    req = 4'b0001; slv = 4'h7;
    cycle(); cycle(); cycle();
    req = 4'b0000;
    cycle();
    chk("abort_gv", {1'b0, gv}, 2'd0);

    // asynchronous reset in LOCK
    req = 4'b0001; slv = 4'h7;
    cycle(); cycle(); cycle();
    #2;
    rst = 1'b1;
    #1;
    chk("async_gv", {1'b0, gv}, 2'd0);
    chk("async_grant", grant, 2'd0);
    model_reset();
    req = 4'b0; slv = 4'h0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    req = 4'b0001;
    cycle();
    chk("post_rst_grant", grant, 2'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      req = 4'($urandom);
      slv = ($urandom_range(0, 1) == 1) ? 4'h7 : 4'($urandom_range(0, 15));
      s7  = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
